// File: rtl/csr_trap_unit_if.sv
// Bus between the control FSM / CSR datapath and the machine-mode trap unit.
// The master side drives requests; the slave side returns CSR and PC-mux values.
interface csr_trap_unit_if;
  logic        intr;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] pc;
  logic        int_taken;
  logic        mret_exec;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie;
  logic        int_req;

  modport master (
    output intr, csr_we, csr_addr, csr_wdata, pc, int_taken, mret_exec,
    input  csr_rdata, mtvec, mepc, mie, int_req
  );

  modport slave (
    input  intr, csr_we, csr_addr, csr_wdata, pc, int_taken, mret_exec,
    output csr_rdata, mtvec, mepc, mie, int_req
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSRs (mstatus, mtvec, mepc, mcause) and external interrupt
// bookkeeping for the multicycle core.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MCAUSE_EXT  = 32'h8000_000B,
  parameter int          SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  csr_trap_unit_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   pending_r;
  logic                   rise_s;
  logic [31:0]            mtvec_r;
  logic [31:0]            mepc_r;
  logic [31:0]            mcause_r;
  logic                   mie_r;
  logic                   mpie_r;
  logic [31:0]            rdata_s;

  assign rise_s = sync_r[SYNC_STAGES-1] & ~prev_r;

  // Synchroniser, previous-value flop and pending latch; a new edge beats int_taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r    <= '0;
      prev_r    <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.intr};
      prev_r <= sync_r[SYNC_STAGES-1];
      if (rise_s) begin
        pending_r <= 1'b1;
      end else if (bus.int_taken) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // CSR state; trap entry beats MRET beats software writes, losers are dropped whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtvec_r  <= MTVEC_RESET;
      mepc_r   <= 32'h0000_0000;
      mcause_r <= 32'h0000_0000;
      mie_r    <= 1'b0;
      mpie_r   <= 1'b0;
    end else if (bus.int_taken) begin
      mepc_r   <= bus.pc & WORD_MASK;
      mcause_r <= MCAUSE_EXT;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else if (bus.mret_exec) begin
      mie_r  <= mpie_r;
      mpie_r <= 1'b1;
    end else if (bus.csr_we) begin
      case (bus.csr_addr)
        ADDR_MSTATUS: begin
          mie_r  <= bus.csr_wdata[3];
          mpie_r <= bus.csr_wdata[7];
        end
        ADDR_MTVEC:  mtvec_r  <= bus.csr_wdata & WORD_MASK;
        ADDR_MEPC:   mepc_r   <= bus.csr_wdata & WORD_MASK;
        ADDR_MCAUSE: mcause_r <= bus.csr_wdata;
        default: begin
          mtvec_r <= mtvec_r;
        end
      endcase
    end else begin
      mtvec_r <= mtvec_r;
    end
  end

  // Read mux over registered state; unmapped addresses read zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (bus.csr_addr)
      ADDR_MSTATUS: rdata_s = {24'h00_0000, mpie_r, 3'b000, mie_r, 3'b000};
      ADDR_MTVEC:   rdata_s = mtvec_r;
      ADDR_MEPC:    rdata_s = mepc_r;
      ADDR_MCAUSE:  rdata_s = mcause_r;
      default:      rdata_s = 32'h0000_0000;
    endcase
  end

  assign bus.csr_rdata = rdata_s;
  assign bus.mtvec     = mtvec_r;
  assign bus.mepc      = mepc_r;
  assign bus.mie       = mie_r;
  assign bus.int_req   = pending_r & mie_r;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: stimulus pushes expected values into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_csr_trap_unit;

  localparam int K_RDATA  = 0;
  localparam int K_MTVEC  = 1;
  localparam int K_MEPC   = 2;
  localparam int K_MIE    = 3;
  localparam int K_INTREQ = 4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  csr_trap_unit_if bus();

  exp_t sb_q[$];
  int   n_total;
  int   n_pass;

  csr_trap_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the DUT at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_RDATA:  act = bus.csr_rdata;
        K_MTVEC:  act = bus.mtvec;
        K_MEPC:   act = bus.mepc;
        K_MIE:    act = {31'd0, bus.mie};
        K_INTREQ: act = {31'd0, bus.int_req};
        default:  act = 32'hXXXX_XXXX;
      endcase
      n_total = n_total + 1;
      if (act === e.exp) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = a;
    bus.csr_wdata = d;
    step();
    bus.csr_we    = 1'b0;
  endtask

  task automatic expect_read(input logic [11:0] a, input logic [31:0] v, input string name);
    bus.csr_addr = a;
    expect_val(K_RDATA, v, name);
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.intr      = 1'b0;
    bus.csr_we    = 1'b0;
    bus.csr_addr  = 12'h000;
    bus.csr_wdata = 32'h0000_0000;
    bus.pc        = 32'h0000_0000;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;
    step();
    rst = 1'b0;

    // Reset state
    expect_val(K_MTVEC, 32'h0000_0000, "rst_mtvec");
    expect_val(K_MEPC, 32'h0000_0000, "rst_mepc");
    expect_val(K_MIE, 32'd0, "rst_mie");
    expect_val(K_INTREQ, 32'd0, "rst_int_req");
    expect_read(12'h300, 32'h0000_0000, "rst_mstatus");
    step();
    expect_read(12'h342, 32'h0000_0000, "rst_mcause");
    step();

    // CSR writes
    csr_write(12'h305, 32'h0000_0103);
    expect_val(K_MTVEC, 32'h0000_0100, "wr_mtvec_out");
    expect_read(12'h305, 32'h0000_0100, "wr_mtvec_rd");
    step();
    csr_write(12'h300, 32'hFFFF_FFFF);
    expect_read(12'h300, 32'h0000_0088, "wr_mstatus_rd");
    expect_val(K_MIE, 32'd1, "wr_mstatus_mie");
    step();
    csr_write(12'h341, 32'h0000_1237);
    expect_val(K_MEPC, 32'h0000_1234, "wr_mepc_out");
    step();
    csr_write(12'h342, 32'hDEAD_BEEF);
    expect_read(12'h342, 32'hDEAD_BEEF, "wr_mcause_rd");
    step();
    csr_write(12'h123, 32'h0000_0005);
    expect_read(12'h123, 32'h0000_0000, "unmapped_rd");
    expect_val(K_MTVEC, 32'h0000_0100, "unmapped_no_side_effect");
    expect_val(K_INTREQ, 32'd0, "idle_int_req");
    step();

    // Interrupt latency: SYNC_STAGES+1 = 3 cycles
    bus.intr = 1'b1;
    step();
    expect_val(K_INTREQ, 32'd0, "lat_cyc1");
    step();
    expect_val(K_INTREQ, 32'd0, "lat_cyc2");
    step();
    expect_val(K_INTREQ, 32'd1, "lat_cyc3");
    step();
    expect_val(K_INTREQ, 32'd1, "lat_hold");

    // Trap entry
    bus.pc        = 32'h0000_0A46;
    bus.int_taken = 1'b1;
    step();
    bus.int_taken = 1'b0;
    expect_val(K_MEPC, 32'h0000_0A44, "trap_mepc");
    expect_read(12'h342, 32'h8000_000B, "trap_mcause");
    expect_val(K_MIE, 32'd0, "trap_mie");
    expect_val(K_INTREQ, 32'd0, "trap_int_req");
    step();
    expect_read(12'h300, 32'h0000_0080, "trap_mstatus");
    step();

    // MRET with intr still held: no second request
    bus.mret_exec = 1'b1;
    step();
    bus.mret_exec = 1'b0;
    expect_read(12'h300, 32'h0000_0088, "mret_mstatus");
    expect_val(K_MIE, 32'd1, "mret_mie");
    expect_val(K_INTREQ, 32'd0, "held_no_second_req");
    step();
    step();
    expect_val(K_INTREQ, 32'd0, "held_no_second_req_late");

    // int_taken beats csr_we to mepc
    bus.pc        = 32'h0000_2000;
    bus.int_taken = 1'b1;
    csr_write(12'h341, 32'h0000_5550);
    bus.int_taken = 1'b0;
    expect_val(K_MEPC, 32'h0000_2000, "prio_take_vs_we");
    expect_read(12'h300, 32'h0000_0080, "prio_take_mstatus");
    step();

    // mret beats csr_we to mstatus
    bus.mret_exec = 1'b1;
    csr_write(12'h300, 32'h0000_0000);
    bus.mret_exec = 1'b0;
    expect_read(12'h300, 32'h0000_0088, "prio_mret_vs_we");
    step();

    // New edge in the int_taken cycle keeps pending set
    bus.intr = 1'b0;
    repeat (4) step();
    bus.intr = 1'b1;
    step();
    step();
    bus.pc        = 32'h0000_3000;
    bus.int_taken = 1'b1;
    step();
    bus.int_taken = 1'b0;
    expect_val(K_MEPC, 32'h0000_3000, "edge_take_mepc");
    expect_val(K_INTREQ, 32'd0, "edge_take_masked");
    bus.mret_exec = 1'b1;
    step();
    bus.mret_exec = 1'b0;
    expect_val(K_INTREQ, 32'd1, "edge_take_pending_kept");
    step();

    // Reset while pending
    bus.intr = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    expect_val(K_MTVEC, 32'h0000_0000, "rst2_mtvec");
    expect_val(K_MEPC, 32'h0000_0000, "rst2_mepc");
    step();
    csr_write(12'h300, 32'h0000_0008);
    expect_val(K_MIE, 32'd1, "rst2_mie_set");
    expect_val(K_INTREQ, 32'd0, "rst2_pending_cleared");
    step();
    step();
    expect_val(K_INTREQ, 32'd0, "rst2_pending_cleared_late");
    step();
    step();

    if (sb_q.size() != 0) begin
      n_total = n_total + 1;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
